// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with match counting and target completion
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   cfg_valid/ready    configuration handshake (accepted only in IDLE)
//   cfg_pattern/len    pattern (bit [len-1] arrives first) and its length, 1..MAXLEN
//   cfg_overlap        1 allows overlapping matches
//   cfg_target         match count that ends a run, 0 runs until aborted
//   cfg_err            one-cycle pulse when an offered configuration is rejected
//   start, abort       arm from IDLE / disarm from ARMED
//   x_valid, x         qualified serial input bit
//   match, done        one-cycle pulses per match / on reaching the target
//   busy, match_count  ARMED indicator and matches counted in the current or last run
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              x_valid,
    input  logic              x,
    output logic              match,
    output logic              done,
    output logic              busy,
    output logic [CNTW-1:0]   match_count
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;
    state_t            state_q, state_d;
    logic              loaded_q, loaded_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [3:0]        len_q, len_d;
    logic              ov_q, ov_d;
    logic [CNTW-1:0]   tgt_q, tgt_d;
    logic [MAXLEN-2:0] hist_q, hist_d;
    logic [3:0]        fill_q, fill_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              err_q, err_d;
    logic              cfg_legal;
    logic [MAXLEN-1:0] hist_sh;
    logic [MAXLEN-1:0] mask;
    logic [3:0]        fill_inc;
    logic [CNTW-1:0]   cnt_inc;
    logic              hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            loaded_q <= 1'b0;
            pat_q    <= '0;
            len_q    <= '0;
            ov_q     <= 1'b0;
            tgt_q    <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ov_q     <= ov_d;
            tgt_q    <= tgt_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            err_q    <= err_d;
        end
    end

    // The history holds MAXLEN-1 past bits; the incoming bit completes the compare window.
    always_comb begin
        cfg_legal = cfg_len != 4'd0 && cfg_len <= 4'(MAXLEN);
        hist_sh   = {hist_q, x};
        for (int i = 0; i < MAXLEN; i++) mask[i] = i < int'(len_q);
        fill_inc  = fill_q >= len_q ? len_q : fill_q + 4'd1;
        cnt_inc   = &cnt_q ? cnt_q : cnt_q + CNTW'(1);
        hit       = fill_inc >= len_q && ((hist_sh ^ pat_q) & mask) == '0;
    end

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ov_d     = ov_q;
        tgt_d    = tgt_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        match_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = cfg_valid && !cfg_legal;
                if (cfg_valid && cfg_legal) begin
                    pat_d    = cfg_pattern;
                    len_d    = cfg_len;
                    ov_d     = cfg_overlap;
                    tgt_d    = cfg_target;
                    loaded_d = 1'b1;
                end
                // A legal config offered with start is latched this edge and used by the run.
                if (start && (loaded_q || (cfg_valid && cfg_legal))) begin
                    state_d = S_ARMED;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (x_valid) begin
                    hist_d = hist_sh[MAXLEN-2:0];
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!ov_q) fill_d = '0;
                        if (tgt_q != '0 && cnt_inc == tgt_q) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = state_q == S_IDLE;
        busy        = state_q == S_ARMED;
        done        = state_q == S_DONE;
        match       = match_q;
        cfg_err     = err_q;
        match_count = cnt_q;
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized checks of seq_det_ctrl against a bit-list reference model
module tb_seq_det_ctrl;
    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [3:0]        cfg_len;
    logic              cfg_overlap;
    logic [CNTW-1:0]   cfg_target;
    logic              cfg_err;
    logic              start;
    logic              abort;
    logic              x_valid;
    logic              x;
    logic              match;
    logic              done;
    logic              busy;
    logic [CNTW-1:0]   match_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state 0 idle, 1 armed, 2 done; received bits kept as a list.
    int              m_state;
    bit              m_loaded;
    logic [7:0]      m_pat;
    int              m_len;
    bit              m_ov;
    int              m_tgt;
    int              m_cnt;
    bit              m_match;
    bit              m_err;
    bit              hq[$];
    int              m_last;

    always #5 clk = ~clk;

    seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .abort(abort),
        .x_valid(x_valid), .x(x), .match(match), .done(done), .busy(busy),
        .match_count(match_count)
    );

    task automatic model_reset;
        m_state = 0; m_loaded = 0; m_pat = 0; m_len = 0; m_ov = 0; m_tgt = 0;
        m_cnt = 0; m_match = 0; m_err = 0; m_last = 0;
        hq.delete();
    endtask

    // A match is the last len received bits equal to the pattern, with the window
    // starting no earlier than the end of the previous match when overlap is off.
    task automatic model_step;
        bit legal;
        bit ok;
        int n;
        m_match = 0;
        m_err = 0;
        if (m_state == 0) begin
            legal = cfg_len >= 1 && int'(cfg_len) <= MAXLEN;
            if (cfg_valid && legal) begin
                m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap; m_tgt = cfg_target;
                m_loaded = 1;
            end
            if (cfg_valid && !legal) m_err = 1;
            if (start && m_loaded) begin
                m_state = 1; hq.delete(); m_cnt = 0; m_last = 0;
            end
        end else if (m_state == 1) begin
            if (abort) begin
                m_state = 0;
            end else if (x_valid) begin
                hq.push_back(x);
                n = hq.size();
                if (n - m_last >= m_len) begin
                    ok = 1;
                    for (int i = 0; i < m_len; i++) if (hq[n-1-i] != m_pat[i]) ok = 0;
                    if (ok) begin
                        m_match = 1;
                        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
                        if (!m_ov) m_last = n;
                        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                    end
                end
            end
        end else begin
            m_state = 0;
        end
    endtask

    task automatic tick(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                        input logic ov, input logic [7:0] tgt, input logic st,
                        input logic ab, input logic xv, input logic xb);
        cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
        start = st; abort = ab; x_valid = xv; x = xb;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_tick;
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        reset = 1;
        cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
        start = 0; abort = 0; x_valid = 0; x = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        n_cmp++; if ({match, done, busy, cfg_err} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses: got %b want 0000", {match, done, busy, cfg_err}); end
        n_cmp++; if (match_count !== 8'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", match_count); end
    endtask

    task automatic test_bad_cfg;
        tick(1, 8'h5, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_len0: got %b want 1", cfg_err); end
        idle_tick();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width: got %b want 0", cfg_err); end
        tick(1, 8'h5, 4'(MAXLEN + 1), 0, 0, 0, 0, 0, 0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_len_max1: got %b want 1", cfg_err); end
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_unloaded: busy got %b want 0", busy); end
        idle_tick();
    endtask

    task automatic test_overlap(input bit ov);
        logic [6:0] s;
        logic [6:0] obs;
        logic [6:0] want;
        bit         any_done;
        s = 7'b1011011;
        want = ov ? 7'b1001000 : 7'b0001000;
        any_done = 0;
        tick(1, 8'b1011, 4, ov, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ov%0d_busy: got %b want 1", ov, busy); end
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 1, s[6-i]);
            obs[i] = match;
            if (done) any_done = 1;
        end
        n_cmp++; if (obs !== want) begin n_bad++; $display("FAIL ov%0d_matches: got %b want %b", ov, obs, want); end
        n_cmp++; if (match_count !== (ov ? 8'd2 : 8'd1)) begin n_bad++; $display("FAIL ov%0d_count: got %0d want %0d", ov, match_count, ov ? 2 : 1); end
        n_cmp++; if (any_done !== 1'b0) begin n_bad++; $display("FAIL ov%0d_done: got %b want 0", ov, any_done); end
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (cfg_ready !== 1'b1 || match_count !== (ov ? 8'd2 : 8'd1)) begin n_bad++; $display("FAIL ov%0d_abort_hold: ready %b count %0d", ov, cfg_ready, match_count); end
    endtask

    task automatic test_target;
        logic [4:0] s;
        logic [4:0] obs_m;
        logic [4:0] obs_d;
        s = 5'b10101;
        tick(1, 8'b101, 3, 1, 2, 1, 0, 0, 0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tgt_cfg_start_busy: got %b want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 1, s[4-i]);
            obs_m[i] = match;
            obs_d[i] = done;
        end
        n_cmp++; if (obs_m !== 5'b10100) begin n_bad++; $display("FAIL tgt_matches: got %b want 10100", obs_m); end
        n_cmp++; if (obs_d !== 5'b10000) begin n_bad++; $display("FAIL tgt_done: got %b want 10000", obs_d); end
        n_cmp++; if ({busy, cfg_ready, match_count} !== {2'b00, 8'd2}) begin n_bad++; $display("FAIL tgt_done_cycle: busy %b ready %b count %0d", busy, cfg_ready, match_count); end
        idle_tick();
        n_cmp++; if ({cfg_ready, done, match_count} !== {2'b10, 8'd2}) begin n_bad++; $display("FAIL tgt_back_idle: ready %b done %b count %0d", cfg_ready, done, match_count); end
    endtask

    task automatic test_abort;
        tick(1, 8'b11, 2, 1, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick(0, 0, 0, 0, 0, 0, 1, 1, 1);
        n_cmp++; if (match !== 1'b0) begin n_bad++; $display("FAIL abort_match: got %b want 0", match); end
        n_cmp++; if (match_count !== 8'd0) begin n_bad++; $display("FAIL abort_count: got %0d want 0", match_count); end
        n_cmp++; if ({busy, cfg_ready, done} !== 3'b010) begin n_bad++; $display("FAIL abort_state: got %b want 010", {busy, cfg_ready, done}); end
    endtask

    task automatic test_reset_midrun;
        tick(1, 8'b1, 1, 1, 0, 1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (match_count !== 8'd3) begin n_bad++; $display("FAIL mid_count: got %0d want 3", match_count); end
        #2;
        reset = 1;
        model_reset();
        #1;
        n_cmp++; if ({busy, match, match_count} !== 10'd0) begin n_bad++; $display("FAIL mid_async: busy %b match %b count %0d", busy, match, match_count); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", cfg_ready); end
        #1;
        reset = 0;
        tick(0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_start_unloaded: busy got %b want 0", busy); end
    endtask

    task automatic test_random;
        logic [3:0]  len;
        logic [12:0] got;
        logic [12:0] exp;
        for (int c = 0; c < 1500; c++) begin
            len = $urandom_range(0, 4) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            tick($urandom_range(0, 9) == 0, 8'($urandom), len, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 4)), $urandom_range(0, 6) == 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
            got = {match, done, busy, cfg_ready, cfg_err, match_count};
            exp = {m_match, m_state == 2, m_state == 1, m_state == 0, m_err, 8'(m_cnt)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL rand_cycle%0d: {match,done,busy,ready,err,count} got %b want %b", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bad_cfg();
        test_overlap(1);
        test_overlap(0);
        test_target();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller for the bit-serial input path. It accepts a pattern configuration of 1 to MAXLEN bits through a valid/ready port. After `start`, it arms and scans qualified input bits, pulsing `match` on each occurrence. It counts matches and signals `done` when a programmed target count is reached. It replaces the fixed-pattern Mealy detectors with one sequenced, reconfigurable resource.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..15).
- CNTW, 8: width of the match counter and the target.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted; high only in IDLE.
- cfg_pattern  in  MAXLEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] is the last.
- cfg_len  in  4  pattern length; legal range 1..MAXLEN.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cfg_target  in  CNTW  match count that ends the run; 0 = run until aborted.
- cfg_err  out  1  one-cycle pulse: configuration rejected.
- start  in  1  arm the detector (IDLE only).
- abort  in  1  disarm without `done`.
- x_valid  in  1  qualifies `x` this cycle.
- x  in  1  serial data bit.
- match  out  1  one-cycle pulse per detected pattern.
- done  out  1  one-cycle pulse when the target count is reached.
- busy  out  1  high in ARMED.
- match_count  out  CNTW  matches counted in the current or last run.

## Operation
- States:
  - IDLE: cfg_ready=1.
  - ARMED: busy=1.
  - DONE: lasts exactly 1 cycle, done=1; then returns to IDLE.
- Reset values:
  - State IDLE; cfg_ready=1.
  - match, done, busy, cfg_err, match_count = 0.
  - Config-loaded flag cleared; pattern registers 0.
- Configuration handshake, in IDLE with cfg_valid=1:
  - If cfg_len is in 1..MAXLEN: latch pattern, len, overlap and target, and set the config-loaded flag.
  - Otherwise: no register changes and cfg_err pulses the next cycle.
  - Outside IDLE, cfg_valid is not accepted; the offerer holds it.
- Start:
  - `start` in IDLE with config loaded: go to ARMED, clear the history, history fill count and match_count.
  - `start` with no valid config ever loaded is ignored.
  - `start` in ARMED or DONE is ignored.
  - cfg_valid and `start` in the same IDLE cycle: the new config (if legal) is latched and the run starts using it. If that config is illegal, the run starts only if a previous config was loaded, and it uses that previous config.
- ARMED datapath, on each cycle with x_valid=1:
  - Shift x into the history LSB.
  - Increment the fill count, saturating at len.
  - A hit occurs when fill ≥ len and history[len-1:0] == pattern[len-1:0].
- On a hit:
  - Pulse `match` and increment match_count.
  - overlap=0: reset the fill count to 0, so the next match needs len fresh bits.
  - overlap=1: history and fill count are kept.
- Completion: if cfg_target ≠ 0 and match_count reaches cfg_target, go to DONE.
- Target 0: never goes to DONE; match_count saturates at 2^CNTW−1.
- Abort:
  - `abort` in ARMED: go to IDLE; no `done`; match_count is held.
  - Abort wins over a simultaneous hit: no match pulse, no count increment.
  - `abort` in IDLE or DONE has no effect.
- x_valid in IDLE or DONE is ignored; history is not updated.
- match_count holds its value in IDLE until the next accepted `start`.

## Timing
- x_valid sampled at edge k → `match` high and match_count updated in cycle k+1 (one-cycle registered latency).
- Final match sampled at edge k → `match`, `done` and DONE state all in cycle k+1; busy=0 in k+1; IDLE and cfg_ready=1 in k+2.
- `start` sampled at edge k → busy=1 in cycle k+1; the first bit is accepted at the edge ending cycle k+1.
- Back-to-back x_valid every cycle is supported with no bubbles; overlapping hits can pulse `match` on consecutive cycles.
- Reset asserted mid-run: all outputs and state go to reset values immediately (asynchronous); the config-loaded flag is cleared.
- cfg_err has the same one-cycle latency as the handshake.

## Test plan
- Config 1011, len 4, overlap=1, target 0; stream 1,0,1,1,0,1,1 (x_valid every cycle) → `match` after bits 4 and 7; match_count=2; no `done`.
- Same stream with overlap=0 → single `match` after bit 4; match_count=1.
- Config 101, len 3, overlap=1, target 2; stream 1,0,1,0,1 → `match` after bits 3 and 5; `done` coincides with the second match; cfg_ready=1 two cycles after the last bit.
- cfg_len=0, then cfg_len=MAXLEN+1 → cfg_err pulses each time; a following `start` with nothing loaded is ignored (busy stays 0).
- Armed with 11, len 2; stream 1,1 with `abort` asserted on the second bit's cycle → no `match`, match_count=0, state IDLE, no `done`.
- Reset asserted while ARMED with match_count=3 → busy=0 and match_count=0 immediately; a later `start` is ignored until a new config is loaded.
